// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end for one shared ALU: grant in IDLE,
// drive the ALU for one EXEC cycle, then present a registered response in RESP.
module alu_arbiter #(
  parameter int DATA_W = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0,
  input  logic              req1,
  input  logic [3:0]        op0,
  input  logic [3:0]        op1,
  input  logic [DATA_W-1:0] a0,
  input  logic [DATA_W-1:0] b0,
  input  logic [DATA_W-1:0] a1,
  input  logic [DATA_W-1:0] b1,
  output logic              gnt0,
  output logic              gnt1,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [3:0]        alu_op,
  input  logic [DATA_W-1:0] alu_f,
  input  logic              alu_z,
  output logic              rsp_valid,
  output logic              rsp_id,
  output logic [DATA_W-1:0] rsp_f,
  output logic              rsp_z,
  output logic              rsp_err
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t              state_q;
  logic                last_gnt_q;   // 1: requester 1 was granted most recently
  logic [3:0]          op_q;
  logic [DATA_W-1:0]   a_q, b_q;
  logic                id_q;
  logic                rsp_valid_q, rsp_id_q, rsp_z_q, rsp_err_q;
  logic [DATA_W-1:0]   rsp_f_q;
  logic                idle, op_bad_d;

  // Grants are gated by rst_n so nothing is accepted while reset is held.
  assign idle = (state_q == IDLE);
  assign gnt0 = rst_n && idle && req0 && (!req1 || last_gnt_q);
  assign gnt1 = rst_n && idle && req1 && (!req0 || !last_gnt_q);

  always_comb begin
    op_bad_d = 1'b1;
    case (op_q)
      4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111, 4'b1100: op_bad_d = 1'b0;
      default: op_bad_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      last_gnt_q  <= 1'b1;
      op_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      id_q        <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= 1'b0;
      rsp_f_q     <= '0;
      rsp_z_q     <= 1'b0;
      rsp_err_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (gnt0 || gnt1) begin
            op_q       <= gnt1 ? op1 : op0;
            a_q        <= gnt1 ? a1  : a0;
            b_q        <= gnt1 ? b1  : b0;
            id_q       <= gnt1;
            last_gnt_q <= gnt1;
            state_q    <= EXEC;
          end
        end
        EXEC: begin
          // Bad ops never leak ALU outputs into the response.
          rsp_f_q     <= op_bad_d ? '0 : alu_f;
          rsp_z_q     <= op_bad_d ? 1'b0 : alu_z;
          rsp_err_q   <= op_bad_d;
          rsp_id_q    <= id_q;
          rsp_valid_q <= 1'b1;
          state_q     <= RESP;
        end
        RESP: begin
          rsp_valid_q <= 1'b0;
          state_q     <= IDLE;
        end
        default: begin
          rsp_valid_q <= 1'b0;
          state_q     <= IDLE;
        end
      endcase
    end
  end

  // Operand registers only load on a grant, so the ALU inputs hold outside EXEC.
  assign alu_a     = a_q;
  assign alu_b     = b_q;
  assign alu_op    = op_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_f     = rsp_f_q;
  assign rsp_z     = rsp_z_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: directed scenarios then random traffic, all checked
// against a cycle-countdown model of the arbiter plus a behavioural shared ALU.
module tb_alu_arbiter;
  localparam int W = 64;

  logic         clk = 1'b0;
  logic         rst_n, req0, req1;
  logic [3:0]   op0, op1, alu_op;
  logic [W-1:0] a0, b0, a1, b1, alu_a, alu_b, alu_f, rsp_f;
  logic         alu_z, gnt0, gnt1, rsp_valid, rsp_id, rsp_z, rsp_err;

  int checks = 0;
  int failures = 0;

  alu_arbiter #(.DATA_W(W)) dut (
    .clk(clk), .rst_n(rst_n), .req0(req0), .req1(req1), .op0(op0), .op1(op1),
    .a0(a0), .b0(b0), .a1(a1), .b1(b1), .gnt0(gnt0), .gnt1(gnt1),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_f(alu_f), .alu_z(alu_z),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_f(rsp_f), .rsp_z(rsp_z),
    .rsp_err(rsp_err)
  );

  always #5 clk = ~clk;

  function automatic bit op_ok(input logic [3:0] op);
    return op inside {4'd0, 4'd1, 4'd2, 4'd6, 4'd7, 4'd12};
  endfunction

  // Shared ALU; unsupported ops return junk with z=1 so forcing is observable.
  function automatic logic [W-1:0] alu_fn(input logic [3:0] op, input logic [W-1:0] a, b);
    case (op)
      4'd0:    return a & b;
      4'd1:    return a | b;
      4'd2:    return a + b;
      4'd6:    return a - b;
      4'd7:    return ($signed(a) < $signed(b)) ? 64'd1 : 64'd0;
      4'd12:   return ~(a | b);
      default: return a ^ 64'hBAD0_0000_0000_0001;
    endcase
  endfunction

  always_comb begin
    alu_f = alu_fn(alu_op, alu_a, alu_b);
    alu_z = op_ok(alu_op) ? (alu_f == '0) : 1'b1;
  end

  // Model: busy = cycles until arbiter may grant again (2 = ALU cycle, 1 = response cycle).
  int           busy;
  bit           last_was1;
  logic [3:0]   s_op;
  logic [W-1:0] s_a, s_b, m_f;
  logic         s_id, m_rid, m_z, m_err;
  int           grants0, grants1;

  task automatic mreset();
    busy = 0; last_was1 = 1'b1;
    s_op = '0; s_a = '0; s_b = '0; s_id = 1'b0;
    m_f = '0; m_z = 1'b0; m_err = 1'b0; m_rid = 1'b0;
  endtask

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs, check outputs at negedge, advance the model at posedge.
  task automatic cyc(input logic r, input logic q0, input logic q1,
                     input logic [3:0] o0, input logic [3:0] o1,
                     input logic [W-1:0] x0, input logic [W-1:0] y0,
                     input logic [W-1:0] x1, input logic [W-1:0] y1);
    bit e0, e1, win1;
    rst_n = r; req0 = q0; req1 = q1; op0 = o0; op1 = o1;
    a0 = x0; b0 = y0; a1 = x1; b1 = y1;
    if (!r) mreset();
    win1 = (q0 && q1) ? !last_was1 : q1;
    e0 = r && busy == 0 && (q0 || q1) && !win1;
    e1 = r && busy == 0 && (q0 || q1) && win1;
    @(negedge clk);
    chk("gnt0", gnt0, e0);
    chk("gnt1", gnt1, e1);
    chk("gnt_excl", gnt0 & gnt1, 0);
    chk("rsp_valid", rsp_valid, r && busy == 1);
    chk("rsp_id", rsp_id, m_rid);
    chk("rsp_f", rsp_f, m_f);
    chk("rsp_z", rsp_z, m_z);
    chk("rsp_err", rsp_err, m_err);
    chk("alu_op", alu_op, s_op);
    chk("alu_a", alu_a, s_a);
    chk("alu_b", alu_b, s_b);
    @(posedge clk);
    if (!r) mreset();
    else if (busy == 2) begin
      busy = 1; m_rid = s_id; m_err = !op_ok(s_op);
      m_f = m_err ? '0 : alu_fn(s_op, s_a, s_b);
      m_z = !m_err && (m_f == '0);
    end else if (busy == 1) busy = 0;
    else if (e0 || e1) begin
      busy = 2; last_was1 = e1; s_id = e1;
      s_op = e1 ? o1 : o0; s_a = e1 ? x1 : x0; s_b = e1 ? y1 : y0;
      if (e1) grants1++; else grants0++;
    end
    #1;
  endtask

  initial begin
    mreset();
    grants0 = 0; grants1 = 0;
    rst_n = 0; req0 = 0; req1 = 0; op0 = 0; op1 = 0; a0 = 0; b0 = 0; a1 = 0; b1 = 0;
    @(posedge clk); #1;
    cyc(0, 1, 1, 2, 2, 1, 1, 1, 1);   // no grant while in reset
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Single add, operand changed after grant
    cyc(1, 1, 0, 4'b0010, 0, 5, 7, 0, 0);
    cyc(1, 0, 0, 4'b0110, 0, 100, 7, 0, 0);
    cyc(1, 0, 0, 0, 0, 100, 7, 0, 0);
    chk("add_f", rsp_f, 64'd12);
    chk("add_id", rsp_id, 0);

    // Zero result from requester 1
    cyc(1, 0, 1, 0, 4'b0110, 0, 0, 9, 9);
    cyc(1, 0, 0, 0, 0, 0, 0, 3, 1);
    cyc(1, 0, 0, 0, 0, 0, 0, 3, 1);
    chk("zero_z", rsp_z, 1);
    chk("zero_id", rsp_id, 1);

    // Bad op
    cyc(1, 1, 0, 4'b0011, 0, 5, 7, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("bad_err", rsp_err, 1);

    // Contention after reset: alternates starting with requester 0
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
    grants0 = 0; grants1 = 0;
    for (int i = 0; i < 12; i++) cyc(1, 1, 1, 4'd2, 4'd6, i, 3, 50, i);
    chk("cont_g0", grants0, 2);
    chk("cont_g1", grants1, 2);

    // Reset during EXEC after a grant to 0; contended grant then goes to 0 again
    cyc(1, 1, 0, 4'd1, 0, 6, 9, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc(1, 1, 1, 4'd0, 4'd1, 12, 10, 1, 2);
    chk("rst_last_id", s_id, 0);
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);

    // Random traffic
    for (int i = 0; i < 300; i++)
      cyc(($urandom_range(0, 59) != 0), $urandom_range(0, 1), $urandom_range(0, 1),
          4'($urandom), 4'($urandom), {$urandom, $urandom}, {$urandom, $urandom},
          (i % 7 == 0) ? {$urandom, $urandom} : 64'($urandom_range(0, 3)),
          64'($urandom_range(0, 3)));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 SHALL have parameter DATA_W, default 64, operand/result width.
REQ-002 SHALL have port clk  input  1  single clock, all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have ports req0/req1  input  1 each  requester i has an operation pending.
REQ-005 SHALL have ports op0/op1  input  4 each  ALU op code from requester i.
REQ-006 SHALL have ports a0/b0/a1/b1  input  DATA_W each  operands from requester i.
REQ-007 SHALL have ports gnt0/gnt1  output  1 each  one-cycle accept pulse to requester i.
REQ-008 SHALL have ports alu_a/alu_b  output  DATA_W  and alu_op  output  4  to shared ALU.
REQ-009 SHALL have ports alu_f  input  DATA_W  and alu_z  input  1  from shared ALU.
REQ-010 SHALL have port rsp_valid  output  1  response valid, one cycle per accepted request.
REQ-011 SHALL have port rsp_id  output  1  requester index owning the response.
REQ-012 SHALL have ports rsp_f  output  DATA_W, rsp_z  output  1, rsp_err  output  1  result, zero flag, bad-op flag.

Function
REQ-013 SHALL implement FSM states IDLE, EXEC, RESP; IDLE->EXEC on grant, EXEC->RESP unconditionally, RESP->IDLE unconditionally.
REQ-014 SHALL, in IDLE only, assert gnt combinationally for at most one requester with req high; gnt0 and gnt1 never both high.
REQ-015 SHALL arbitrate round-robin: only one requesting -> grant it; both requesting -> grant the one not granted last; last_gnt updates on each grant.
REQ-016 SHALL, on the edge where gnt is high, register op, a, b and requester index.
REQ-017 SHALL drive alu_a/alu_b/alu_op from the registered values in EXEC; outside EXEC hold last values (no toggling).
REQ-018 SHALL, on the edge leaving EXEC, capture alu_f into rsp_f and alu_z into rsp_z.
REQ-019 SHALL assert rsp_valid in RESP for exactly one cycle with rsp_id = granted index; rsp_f/rsp_z/rsp_id/rsp_err hold until the next capture.
REQ-020 SHALL treat op codes {0000,0001,0010,0110,0111,1100} as valid; any other op is accepted, rsp_err=1, rsp_f=0, rsp_z=0 regardless of ALU outputs.
REQ-021 SHALL give latency: gnt in cycle N, rsp_valid in cycle N+2; throughput one request per 3 cycles.
REQ-022 SHALL not grant in EXEC or RESP; requests arriving then wait; a requester may drop req before gnt with no effect.
REQ-023 SHALL ignore requester op/a/b changes after the grant edge.
REQ-024 SHALL allow a new grant in the IDLE cycle directly following RESP.

Reset
REQ-025 SHALL, while rst_n low, force state IDLE, gnt0/gnt1=0, rsp_valid=0, rsp_id=0, rsp_f=0, rsp_z=0, rsp_err=0, alu_a/alu_b=0, alu_op=0.
REQ-026 SHALL reset last_gnt to 1 so requester 0 wins the first contended grant.
REQ-027 SHALL, on reset asserted mid-operation (EXEC or RESP), discard the in-flight request with no rsp_valid after release.
REQ-028 SHALL not grant in the cycle rst_n is low; first grant possible in the first cycle after release.

Verification
REQ-029 Single add: req0=1, op0=0010, a0=5, b0=7 -> gnt0 at N, alu_op=0010 in N+1, rsp_valid at N+2 with rsp_id=0, rsp_f=12, rsp_z=0, rsp_err=0.
REQ-030 Zero result: req1=1, op1=0110, a1=9, b1=9 -> rsp_id=1, rsp_f=0, rsp_z=1.
REQ-031 Contention: req0=req1=1 held continuously after reset -> grants alternate 0,1,0,1 every 3 cycles, never both high.
REQ-032 Bad op: req0=1, op0=0011 -> gnt0, rsp_valid at N+2 with rsp_err=1, rsp_f=0, rsp_z=0.
REQ-033 Operand change after grant: a0 changed from 5 to 100 in N+1 -> rsp_f still reflects a0=5.
REQ-034 Reset mid-op: rst_n low during EXEC, released 2 cycles later -> no rsp_valid, all outputs 0, next contended grant to requester 0.
